// File: rtl/gpio_poll_pkg.sv
// Shared types and constants for the GPIO poll master: FSM state encoding
// and the width of the sample counter.
package gpio_poll_pkg;

  localparam int COUNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } poll_state_e;

endpackage

// File: rtl/gpio_poll_timer.sv
// Poll-rate divider: counts down while enabled, pulses tick at zero and
// reloads; holds its value (no reload) while disabled.
module gpio_poll_timer #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [15:0] RELOAD = 16'(DIV - 1);

  logic [15:0] count_r;

  assign tick = enable && (count_r == 16'd0);

  // Down-counter with reload on expiry; frozen while polling is disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= RELOAD;
    end else if (enable) begin
      if (count_r == 16'd0) begin
        count_r <= RELOAD;
      end else begin
        count_r <= count_r - 16'd1;
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/gpio_poll_master.sv
// Avalon-MM read master that periodically samples a PIO data register and
// reports per-bit rising/falling edges and change events downstream.
module gpio_poll_master
  import gpio_poll_pkg::*;
#(
  parameter int DATA_W       = 2,
  parameter int ADDR_W       = 2,
  parameter int POLL_ADDR    = 0,
  parameter int POLL_DIV     = 1000,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic [ADDR_W-1:0]    avm_address,
  output logic                 avm_read,
  input  logic                 avm_waitrequest,
  input  logic [DATA_W-1:0]    avm_readdata,
  output logic [DATA_W-1:0]    sample_data,
  output logic                 sample_valid,
  output logic [DATA_W-1:0]    rise_mask,
  output logic [DATA_W-1:0]    fall_mask,
  output logic                 change,
  output logic                 overrun,
  output logic [COUNT_W-1:0]   sample_count
);

  poll_state_e       state_r;
  poll_state_e       state_next_s;
  logic [2:0]        lat_r;
  logic              first_done_r;
  logic              tick_s;
  logic              take_s;
  logic [DATA_W-1:0] rise_s;
  logic [DATA_W-1:0] fall_s;

  gpio_poll_timer #(.DIV(POLL_DIV)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick_s)
  );

  assign take_s = (state_r == ST_WAIT) && (lat_r == 3'd0);

  // Next-state logic; avm_read is high exactly while in REQ.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:    if (tick_s) state_next_s = ST_REQ;           else state_next_s = ST_IDLE;
      ST_REQ:     if (!avm_waitrequest) state_next_s = ST_WAIT; else state_next_s = ST_REQ;
      ST_WAIT:    if (lat_r == 3'd0) state_next_s = ST_CAPTURE; else state_next_s = ST_WAIT;
      ST_CAPTURE: state_next_s = ST_IDLE;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // The first sample after reset has no predecessor, so it reports no edges.
  always_comb begin
    rise_s = '0;
    fall_s = '0;
    if (first_done_r) begin
      rise_s = avm_readdata & ~sample_data;
      fall_s = ~avm_readdata & sample_data;
    end else begin
      rise_s = '0;
      fall_s = '0;
    end
  end

  // Bus-side sequencing: state, read strobe, latency counter, overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      lat_r       <= 3'd0;
      avm_read    <= 1'b0;
      avm_address <= ADDR_W'(POLL_ADDR);
      overrun     <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      avm_read    <= (state_next_s == ST_REQ);
      avm_address <= ADDR_W'(POLL_ADDR);
      if ((state_r == ST_REQ) && !avm_waitrequest) begin
        lat_r <= 3'(READ_LATENCY - 1);
      end else if ((state_r == ST_WAIT) && (lat_r != 3'd0)) begin
        lat_r <= lat_r - 3'd1;
      end else begin
        lat_r <= lat_r;
      end
      if (tick_s && (state_r != ST_IDLE)) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
    end
  end

  // Sample path: results become visible in the CAPTURE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      rise_mask    <= '0;
      fall_mask    <= '0;
      change       <= 1'b0;
      sample_count <= '0;
      first_done_r <= 1'b0;
    end else if (take_s) begin
      sample_data  <= avm_readdata;
      sample_valid <= 1'b1;
      rise_mask    <= rise_s;
      fall_mask    <= fall_s;
      change       <= |(rise_s | fall_s);
      sample_count <= sample_count + 16'd1;
      first_done_r <= 1'b1;
    end else begin
      sample_valid <= 1'b0;
      rise_mask    <= '0;
      fall_mask    <= '0;
      change       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpio_poll_master.sv
// Self-checking bench for gpio_poll_master: an event-level model checks the
// default instance every cycle; a second instance with a short period
// exercises overrun.
module tb_gpio_poll_master;

  localparam int DIV = 1000;
  localparam int RL  = 1;

  logic        clk = 1'b0;
  logic        reset, enable, wr;
  logic [1:0]  rd;
  logic [1:0]  a_addr, a_data, a_rise, a_fall;
  logic        a_read, a_valid, a_change, a_over;
  logic [15:0] a_count;

  logic        b_reset, b_enable, b_wr;
  logic [1:0]  b_rd;
  logic [1:0]  b_addr, b_data, b_rise, b_fall;
  logic        b_read, b_valid, b_change, b_over;
  logic [15:0] b_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gpio_poll_master dut_a (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(wr), .avm_readdata(rd),
    .sample_data(a_data), .sample_valid(a_valid), .rise_mask(a_rise), .fall_mask(a_fall),
    .change(a_change), .overrun(a_over), .sample_count(a_count)
  );

  gpio_poll_master #(.POLL_DIV(4)) dut_b (
    .clk(clk), .reset(b_reset), .enable(b_enable),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(b_wr), .avm_readdata(b_rd),
    .sample_data(b_data), .sample_valid(b_valid), .rise_mask(b_rise), .fall_mask(b_fall),
    .change(b_change), .overrun(b_over), .sample_count(b_count)
  );

  // Event-level model of instance A, advanced on every clock edge.
  bit          model_ready = 1'b0;
  bit          asking, busy, fire, m_seen;
  int          now = 0, due_at = -1, take_at = -10, en_cnt = 0;
  logic        m_read, m_valid, m_change, m_over;
  logic [1:0]  m_data, m_rise, m_fall;
  logic [15:0] m_count;

  always @(posedge clk) begin
    now++;
    if (reset) begin
      asking = 1'b0; due_at = -1; take_at = -10; en_cnt = 0; m_seen = 1'b0;
      m_read = 1'b0; m_valid = 1'b0; m_change = 1'b0; m_over = 1'b0;
      m_data = 2'b00; m_rise = 2'b00; m_fall = 2'b00; m_count = 16'd0;
      model_ready = 1'b1;
    end else begin
      busy = asking || (due_at >= 0) || (take_at == now - 1);
      fire = enable && (en_cnt == DIV - 1);
      if (enable) en_cnt = (en_cnt + 1) % DIV;
      m_valid = 1'b0; m_rise = 2'b00; m_fall = 2'b00; m_change = 1'b0;
      if (due_at == now) begin
        m_rise   = m_seen ? (rd & ~m_data) : 2'b00;
        m_fall   = m_seen ? (~rd & m_data) : 2'b00;
        m_change = ((m_rise | m_fall) != 2'b00);
        m_data   = rd;
        m_valid  = 1'b1;
        m_count  = m_count + 16'd1;
        m_seen   = 1'b1;
        due_at   = -1;
        take_at  = now;
      end
      if (asking && !wr) begin
        asking = 1'b0;
        due_at = now + RL;
      end
      if (fire) begin
        if (busy) m_over = 1'b1;
        else      asking = 1'b1;
      end
      m_read = asking;
    end
  end

  int  b_vals = 0, b_polls = 0, b_dups = 0;
  bit  b_prev_valid = 1'b0, b_prev_read = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare instance A against the model, track instance B.
  task automatic cyc();
    @(negedge clk);
    if (model_ready) begin
      chk("avm_read",     32'(a_read),   32'(m_read));
      chk("avm_address",  32'(a_addr),   32'd0);
      chk("sample_data",  32'(a_data),   32'(m_data));
      chk("sample_valid", 32'(a_valid),  32'(m_valid));
      chk("rise_mask",    32'(a_rise),   32'(m_rise));
      chk("fall_mask",    32'(a_fall),   32'(m_fall));
      chk("change",       32'(a_change), 32'(m_change));
      chk("overrun",      32'(a_over),   32'(m_over));
      chk("sample_count", 32'(a_count),  32'(m_count));
    end
    if (!b_reset) begin
      if (b_valid) begin
        b_vals++;
        if (b_prev_valid) b_dups++;
      end
      if (b_read && !b_prev_read) b_polls++;
    end
    b_prev_valid = b_valid;
    b_prev_read  = b_read;
  endtask

  task automatic wait_read(output int n);
    n = 0;
    do begin cyc(); n++; end while (!a_read && n < 5000);
    chk("read_timeout", 32'(n < 5000), 32'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin cyc(); n++; end while (!a_valid && n < 5000);
    chk("valid_timeout", 32'(n < 5000), 32'd1);
  endtask

  int n, hi, vals, reads, stall_vals;

  initial begin
    reset = 1'b1; enable = 1'b1; wr = 1'b0; rd = 2'b01;
    b_reset = 1'b1; b_enable = 1'b1; b_wr = 1'b0; b_rd = 2'b10;
    repeat (3) cyc();
    chk("reset_read",  32'(a_read),  32'd0);
    chk("reset_addr",  32'(a_addr),  32'd0);
    chk("reset_count", 32'(a_count), 32'd0);
    chk("reset_over",  32'(a_over),  32'd0);

    // First poll: 1000 cycles to the read, capture two cycles after acceptance.
    reset = 1'b0;
    wait_read(n);
    chk("first_read_cycle", 32'(n), 32'd1000);
    wait_valid(n);
    chk("capture_delay", 32'(n), 32'd2);
    chk("s1_data",   32'(a_data),   32'h1);
    chk("s1_rise",   32'(a_rise),   32'h0);
    chk("s1_change", 32'(a_change), 32'd0);
    chk("s1_count",  32'(a_count),  32'd1);

    // Input changes 01 -> 10 before the second poll.
    rd = 2'b10;
    wait_valid(n);
    chk("s2_rise",   32'(a_rise),   32'h2);
    chk("s2_fall",   32'(a_fall),   32'h1);
    chk("s2_change", 32'(a_change), 32'd1);
    chk("s2_count",  32'(a_count),  32'd2);

    // Slave stalls for 5 cycles.
    wait_read(n);
    wr = 1'b1; hi = 1;
    repeat (5) begin cyc(); if (a_read) hi++; end
    wr = 1'b0;
    wait_valid(n);
    chk("stall_read_cycles",   32'(hi),     32'd6);
    chk("stall_capture_delay", 32'(n),      32'd2);
    chk("stall_overrun",       32'(a_over), 32'd0);

    // enable dropped while the request is outstanding.
    wait_read(n);
    enable = 1'b0; vals = 0; reads = 0;
    repeat (3010) begin cyc(); if (a_valid) vals++; if (a_read) reads++; end
    chk("disabled_samples", 32'(vals),  32'd1);
    chk("disabled_reads",   32'(reads), 32'd0);
    enable = 1'b1;
    wait_read(n);
    chk("resume_read_cycle", 32'(n), 32'd1000);
    wait_valid(n);

    // Reset during the read-latency wait.
    wait_read(n);
    cyc();
    reset = 1'b1;
    cyc();
    chk("rst_read",   32'(a_read),   32'd0);
    chk("rst_valid",  32'(a_valid),  32'd0);
    chk("rst_data",   32'(a_data),   32'd0);
    chk("rst_count",  32'(a_count),  32'd0);
    chk("rst_change", 32'(a_change), 32'd0);
    reset = 1'b0; rd = 2'b11;
    wait_read(n);
    chk("rst_first_read", 32'(n), 32'd1000);
    wait_valid(n);
    chk("rst_s_change", 32'(a_change), 32'd0);
    chk("rst_s_rise",   32'(a_rise),   32'd0);
    chk("rst_s_data",   32'(a_data),   32'h3);
    chk("rst_s_count",  32'(a_count),  32'd1);

    // Short-period instance: a 10-cycle stall must raise sticky overrun.
    b_reset = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (!b_read && n < 50);
    chk("b_first_read", 32'(n), 32'd4);
    chk("b_over_before", 32'(b_over), 32'd0);
    b_wr = 1'b1;
    repeat (10) cyc();
    stall_vals = b_vals;
    chk("b_over_stall", 32'(b_over), 32'd1);
    b_wr = 1'b0;
    repeat (40) cyc();
    chk("b_stall_samples", 32'(stall_vals), 32'd0);
    chk("b_over_sticky",   32'(b_over),     32'd1);
    chk("b_dup_valid",     32'(b_dups),     32'd0);
    chk("b_count_match",   32'(b_count),    32'(b_vals));
    chk("b_polls_vs_samples", 32'((b_polls - b_vals) >= 0 && (b_polls - b_vals) <= 1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
